// File: rtl/treasure_color_classifier.sv
// Red/blue pixel classifier on the frame-buffer scan-out stream. Counts classified
// pixels inside the camera window, decides per frame at vsync and debounces RESULT.
module treasure_color_classifier #(
   parameter int SCREEN_WIDTH  = 176,
   parameter int SCREEN_HEIGHT = 144,
   parameter int COUNT_W       = 15,
   parameter int RED_THRESH    = 2000,
   parameter int BLUE_THRESH   = 2000,
   parameter int LARGE_THRESH  = 6000,
   parameter int AGREE_FRAMES  = 2,
   parameter int HIGHLIGHT     = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] PIXEL_IN,
   input  logic [9:0] VGA_PIXEL_X,
   input  logic [9:0] VGA_PIXEL_Y,
   input  logic       VGA_VSYNC_NEG,
   output logic [7:0] PIXEL_OUT,
   output logic [2:0] RESULT,
   output logic       RESULT_VALID,
   output logic       FRAME_DONE
);

   typedef enum logic [1:0] {ACCUM = 2'd0, DECIDE = 2'd1, COMMIT = 2'd2} state_t;

   localparam logic [9:0]         WIN_W   = 10'(SCREEN_WIDTH);
   localparam logic [9:0]         WIN_H   = 10'(SCREEN_HEIGHT);
   localparam logic [31:0]        RED_T   = 32'(RED_THRESH);
   localparam logic [31:0]        BLUE_T  = 32'(BLUE_THRESH);
   localparam logic [31:0]        LARGE_T = 32'(LARGE_THRESH);
   localparam logic [2:0]         AGREE_N = 3'(AGREE_FRAMES);
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   state_t             state, state_nxt;
   logic [9:0]         x_d, y_d;
   logic               vs_q;
   logic [COUNT_W-1:0] red_cnt, blue_cnt;
   logic [31:0]        red_w, blue_w;
   logic [2:0]         cand, cand_nxt, last_cand;
   logic [2:0]         agree, agree_nxt;
   logic [2:0]         pr, pg;
   logic [1:0]         pb;
   logic               in_win, is_red, is_blue, vs_fall;
   logic               accum_en, decide_en, commit_en;
   logic [7:0]         pix_nxt;

   // PIXEL_IN arrives one clock after its coordinates, so pair it with x_d/y_d.
   assign in_win  = (x_d < WIN_W) && (y_d < WIN_H);
   assign pr      = PIXEL_IN[7:5];
   assign pg      = PIXEL_IN[4:2];
   assign pb      = PIXEL_IN[1:0];
   assign is_red  = (pr >= 3'd5) && (pg <= 3'd2) && (pb <= 2'd1);
   assign is_blue = (pb >= 2'd2) && (pr <= 3'd2) && (pg <= 3'd3);
   assign vs_fall = vs_q && !VGA_VSYNC_NEG;
   assign red_w   = 32'(red_cnt);
   assign blue_w  = 32'(blue_cnt);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= ACCUM;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (vs_fall) state_nxt = DECIDE;
         DECIDE:  state_nxt = COMMIT;
         COMMIT:  state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_comb begin
      accum_en  = 1'b0;
      decide_en = 1'b0;
      commit_en = 1'b0;
      case (state)
         ACCUM:   accum_en  = 1'b1;
         DECIDE:  decide_en = 1'b1;
         COMMIT:  commit_en = 1'b1;
         default: ;
      endcase
   end

   // A tie, or neither colour over threshold, yields 000.
   always_comb begin
      cand_nxt = 3'b000;
      if ((red_w >= RED_T) && (red_w > blue_w))
         cand_nxt = {red_w >= LARGE_T, 2'b01};
      else if ((blue_w >= BLUE_T) && (blue_w > red_w))
         cand_nxt = {blue_w >= LARGE_T, 2'b10};
   end

   always_comb begin
      agree_nxt = 3'd1;
      if (cand == last_cand)
         agree_nxt = (agree >= AGREE_N) ? AGREE_N : agree + 3'd1;
   end

   always_comb begin
      pix_nxt = PIXEL_IN;
      if ((HIGHLIGHT != 0) && in_win) begin
         if (is_red)       pix_nxt = 8'hE0;
         else if (is_blue) pix_nxt = 8'h03;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         x_d          <= '0;
         y_d          <= '0;
         vs_q         <= 1'b1;
         PIXEL_OUT    <= '0;
         red_cnt      <= '0;
         blue_cnt     <= '0;
         cand         <= '0;
         last_cand    <= '0;
         agree        <= '0;
         RESULT       <= '0;
         RESULT_VALID <= 1'b0;
         FRAME_DONE   <= 1'b0;
      end else begin
         x_d        <= VGA_PIXEL_X;
         y_d        <= VGA_PIXEL_Y;
         vs_q       <= VGA_VSYNC_NEG;
         PIXEL_OUT  <= pix_nxt;
         FRAME_DONE <= commit_en;
         if (decide_en) begin
            cand     <= cand_nxt;
            red_cnt  <= '0;
            blue_cnt <= '0;
         end else if (accum_en && in_win) begin
            if (is_red && (red_cnt != CNT_MAX))   red_cnt  <= red_cnt + 1'b1;
            if (is_blue && (blue_cnt != CNT_MAX)) blue_cnt <= blue_cnt + 1'b1;
         end
         if (commit_en) begin
            agree     <= agree_nxt;
            last_cand <= cand;
            if (agree_nxt == AGREE_N) begin
               RESULT       <= cand;
               RESULT_VALID <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_treasure_color_classifier.sv
// Randomized bench for treasure_color_classifier: frames are built as pixel lists,
// played through the DUT and scored against a per-frame count/decision model.
module tb_treasure_color_classifier;

   localparam int CW   = 8;
   localparam int RT   = 40;
   localparam int BT   = 40;
   localparam int LT   = 120;
   localparam int AF   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] PIXEL_IN = 8'h00;
   logic [9:0] VGA_PIXEL_X = 10'd700;
   logic [9:0] VGA_PIXEL_Y = 10'd700;
   logic       VGA_VSYNC_NEG = 1'b1;
   logic [7:0] PIXEL_OUT;
   logic [2:0] RESULT;
   logic       RESULT_VALID;
   logic       FRAME_DONE;

   treasure_color_classifier #(
      .SCREEN_WIDTH(176), .SCREEN_HEIGHT(144), .COUNT_W(CW),
      .RED_THRESH(RT), .BLUE_THRESH(BT), .LARGE_THRESH(LT),
      .AGREE_FRAMES(AF), .HIGHLIGHT(1)
   ) dut (
      .CLK(CLK), .RESET(RESET), .PIXEL_IN(PIXEL_IN),
      .VGA_PIXEL_X(VGA_PIXEL_X), .VGA_PIXEL_Y(VGA_PIXEL_Y),
      .VGA_VSYNC_NEG(VGA_VSYNC_NEG), .PIXEL_OUT(PIXEL_OUT),
      .RESULT(RESULT), .RESULT_VALID(RESULT_VALID), .FRAME_DONE(FRAME_DONE)
   );

   always #20 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   int m_red, m_blue, m_last, m_agree, m_result;
   bit m_valid;

   int         q_x[$];
   int         q_y[$];
   logic [7:0] q_p[$];

   // 1 = red, 2 = blue, 0 = neither
   function automatic int cls(input logic [7:0] p);
      int r, g, b;
      r = int'(p) / 32;
      g = (int'(p) / 4) % 8;
      b = int'(p) % 4;
      if (r >= 5 && g <= 2 && b <= 1) return 1;
      if (b >= 2 && r <= 2 && g <= 3) return 2;
      return 0;
   endfunction

   function automatic logic [7:0] mk(input int c);
      int r, g, b;
      case (c)
         1: begin r = $urandom_range(7, 5); g = $urandom_range(2, 0); b = $urandom_range(1, 0); end
         2: begin r = $urandom_range(2, 0); g = $urandom_range(3, 0); b = $urandom_range(3, 2); end
         default: begin
            do begin
               r = $urandom_range(7, 0); g = $urandom_range(7, 0); b = $urandom_range(3, 0);
            end while (cls(8'(r * 32 + g * 4 + b)) != 0);
         end
      endcase
      return 8'(r * 32 + g * 4 + b);
   endfunction

   task automatic push_at(input int c, input int x, input int y);
      q_x.push_back(x);
      q_y.push_back(y);
      q_p.push_back(mk(c));
   endtask

   task automatic push(input int c, input bit inwin);
      int x, y;
      if (inwin) begin
         x = $urandom_range(175, 0); y = $urandom_range(143, 0);
      end else if ($urandom_range(1, 0) == 1) begin
         x = $urandom_range(639, 176); y = $urandom_range(479, 0);
      end else begin
         x = $urandom_range(639, 0); y = $urandom_range(479, 144);
      end
      push_at(c, x, y);
   endtask

   task automatic push_n(input int c, input int n, input bit inwin);
      for (int i = 0; i < n; i++) push(c, inwin);
   endtask

   task automatic model_reset;
      m_red = 0; m_blue = 0; m_last = 0; m_agree = 0; m_result = 0; m_valid = 0;
   endtask

   // Plays the queued frame; PIXEL_IN for coordinate i is driven one clock later.
   task automatic play_frame;
      int n;
      n = q_p.size();
      for (int i = 0; i <= n; i++) begin
         VGA_PIXEL_X = (i < n) ? 10'(q_x[i]) : 10'd700;
         VGA_PIXEL_Y = (i < n) ? 10'(q_y[i]) : 10'd700;
         PIXEL_IN    = (i > 0) ? q_p[i-1] : 8'h00;
         @(posedge CLK); #1;
         if (i > 0) begin
            int c;
            bit w;
            logic [7:0] e;
            c = cls(q_p[i-1]);
            w = (q_x[i-1] < 176) && (q_y[i-1] < 144);
            e = (w && c == 1) ? 8'hE0 : (w && c == 2) ? 8'h03 : q_p[i-1];
            n_cmp++;
            if (PIXEL_OUT !== e) begin
               n_bad++;
               $display("FAIL pixel_out x=%0d y=%0d in=%h got %h want %h",
                        q_x[i-1], q_y[i-1], q_p[i-1], PIXEL_OUT, e);
            end
            if (w && c == 1 && m_red < CMAX) m_red++;
            if (w && c == 2 && m_blue < CMAX) m_blue++;
         end
      end
      PIXEL_IN = 8'h00;
      q_x.delete(); q_y.delete(); q_p.delete();
   endtask

   // Drops vsync and checks the decision pipeline edge by edge.
   task automatic do_vsync(input bit glitch);
      int c, old_res, exp_r;
      bit old_valid, exp_v, exp_fd;
      c = 0;
      if (m_red >= RT && m_red > m_blue)       c = ((m_red >= LT) ? 4 : 0) + 1;
      else if (m_blue >= BT && m_blue > m_red) c = ((m_blue >= LT) ? 4 : 0) + 2;
      m_red = 0; m_blue = 0;
      if (c == m_last) m_agree = (m_agree + 1 > AF) ? AF : m_agree + 1;
      else begin m_last = c; m_agree = 1; end
      old_res = m_result; old_valid = m_valid;
      if (m_agree == AF) begin m_result = c; m_valid = 1; end
      VGA_VSYNC_NEG = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge CLK); #1;
         if (glitch) VGA_VSYNC_NEG = (k == 1);
         exp_fd = (k == 3);
         exp_r  = (k >= 3) ? m_result : old_res;
         exp_v  = (k >= 3) ? m_valid : old_valid;
         n_cmp++;
         if (FRAME_DONE !== exp_fd || RESULT !== 3'(exp_r) || RESULT_VALID !== exp_v) begin
            n_bad++;
            $display("FAIL vsync edge E+%0d got done=%b res=%b vld=%b want done=%b res=%b vld=%b",
                     k - 1, FRAME_DONE, RESULT, RESULT_VALID, exp_fd, 3'(exp_r), exp_v);
         end
      end
      VGA_VSYNC_NEG = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic check_zero(input string tag);
      n_cmp++;
      if (PIXEL_OUT !== 8'h00 || RESULT !== 3'b000 || RESULT_VALID !== 1'b0 || FRAME_DONE !== 1'b0) begin
         n_bad++;
         $display("FAIL %s got pix=%h res=%b vld=%b done=%b want all zero",
                  tag, PIXEL_OUT, RESULT, RESULT_VALID, FRAME_DONE);
      end
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check_zero("reset_state");
      RESET = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check_zero("after_release");
   endtask

   task automatic test_red_frames;
      for (int f = 0; f < 3; f++) begin
         push_n(1, 200, 1);
         play_frame();
         do_vsync(0);
      end
   endtask

   task automatic test_saturation;
      // counter wrap would turn the large-red frame into small red, the tie into red
      for (int f = 0; f < 2; f++) begin
         push_n(1, 300, 1); push_n(0, 20, 1);
         play_frame(); do_vsync(0);
      end
      for (int f = 0; f < 2; f++) begin
         push_n(1, 300, 1); push_n(2, 270, 1);
         play_frame(); do_vsync(0);
      end
   endtask

   task automatic test_blue;
      for (int f = 0; f < AF; f++) begin
         push_n(0, 50, 1); push_n(2, 60, 1); push_n(0, 50, 1);
         play_frame(); do_vsync(0);
      end
   endtask

   task automatic test_alternate_and_tie;
      for (int f = 0; f < 4; f++) begin
         push_n((f % 2 == 0) ? 1 : 2, 70, 1);
         play_frame(); do_vsync(f == 1);
      end
      for (int f = 0; f < 2; f++) begin
         push_n(1, 50, 1); push_n(2, 50, 1); push_n(0, 30, 1);
         play_frame(); do_vsync(0);
      end
   endtask

   task automatic test_out_of_window;
      for (int f = 0; f < 2; f++) begin
         push_n(1, 150, 0);
         push_at(1, 176, 0); push_at(1, 0, 144); push_at(1, 639, 479);
         push_at(1, 175, 143);
         play_frame(); do_vsync(0);
      end
   endtask

   task automatic test_random;
      for (int f = 0; f < 12; f++) begin
         int pr, pb, r;
         pr = $urandom_range(70, 0);
         pb = $urandom_range(70, 0);
         for (int i = 0; i < 150; i++) begin
            r = $urandom_range(99, 0);
            push((r < pr) ? 1 : (r < pr + pb) ? 2 : 0, $urandom_range(9, 0) != 0);
         end
         push_at(2, 175, 143); push_at(2, 176, 143); push_at(2, 175, 144);
         play_frame(); do_vsync(f == 5);
      end
   endtask

   task automatic test_reset_decide;
      push_n(1, 60, 1);
      play_frame();
      VGA_VSYNC_NEG = 1'b0;
      @(posedge CLK); #1;
      RESET = 1'b1;
      #1;
      check_zero("reset_in_decide");
      VGA_VSYNC_NEG = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      model_reset();
      push_n(1, 60, 1);
      play_frame(); do_vsync(0);
      // mid-frame reset drops the partial large-red count
      push_n(1, 150, 1);
      play_frame();
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      model_reset();
      for (int f = 0; f < AF; f++) begin
         push_n(2, 50, 1);
         play_frame(); do_vsync(0);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_red_frames();
      test_saturation();
      test_blue();
      test_alternate_and_tie();
      test_out_of_window();
      test_random();
      test_reset_decide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      repeat (80000) @(posedge CLK);
      $display("FAIL timeout cycle budget exhausted");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/treasure_color_classifier.md
# treasure_color_classifier

Downstream consumer of the frame buffer: watches the RGB332 pixel stream that the M9K buffer returns during VGA scan-out, counts red and blue pixels inside the 176x144 camera window, and classifies each frame at the VGA vertical-sync edge. A multi-frame agreement filter debounces the decision before it drives the 3-bit RESULT bus to the Arduino. The block also returns a one-cycle-delayed, optionally highlighted pixel to the VGA driver.

## Interface
- SCREEN_WIDTH, 176, active window width in pixels
- SCREEN_HEIGHT, 144, active window height in lines
- COUNT_W, 15, width of the pixel counters; counters saturate at all-ones
- RED_THRESH, 2000, minimum red count for a red decision
- BLUE_THRESH, 2000, minimum blue count for a blue decision
- LARGE_THRESH, 6000, winning-colour count at or above which RESULT[2] is set
- AGREE_FRAMES, 2, consecutive identical candidates (1..7) required before RESULT changes
- HIGHLIGHT, 1, 1 = classified pixels recoloured on PIXEL_OUT; 0 = plain pass-through
- CLK  in  1  single clock (25 MHz VGA clock); all logic runs on its rising edge
- RESET  in  1  asynchronous reset, active-high
- PIXEL_IN  in  8  RGB332 from memory, valid one CLK after the matching coordinates
- VGA_PIXEL_X  in  10  current scan column from the VGA driver
- VGA_PIXEL_Y  in  10  current scan line from the VGA driver
- VGA_VSYNC_NEG  in  1  VGA vertical sync, active low
- PIXEL_OUT  out  8  registered pixel to the VGA driver
- RESULT  out  3  [1:0] colour: 00 none, 01 red, 10 blue; [2] large
- RESULT_VALID  out  1  high once the first RESULT has been committed after reset
- FRAME_DONE  out  1  one-CLK pulse per classified frame

## Operation
- Alignment: VGA_PIXEL_X/Y are registered once (x_d, y_d). PIXEL_IN is paired with x_d/y_d. In-window means x_d < SCREEN_WIDTH and y_d < SCREEN_HEIGHT.
- Pixel class (R=[7:5], G=[4:2], B=[1:0]):
  - red: R >= 5, G <= 2, B <= 1.
  - blue: B >= 2, R <= 2, G <= 3.
  - Otherwise unclassified. No pixel is ever both.
- Counters red_cnt and blue_cnt increment by 1 for each in-window classified pixel while in state ACCUM. They saturate at 2^COUNT_W-1 and never wrap.
- PIXEL_OUT when HIGHLIGHT=1:
  - red pixel -> 8'hE0
  - blue pixel -> 8'h03
  - otherwise PIXEL_IN
- PIXEL_OUT when HIGHLIGHT=0: always PIXEL_IN. Either way PIXEL_OUT is registered, and out-of-window pixels pass through unmodified.
- FSM states: ACCUM -> DECIDE -> COMMIT -> ACCUM.
  - ACCUM: count pixels. Leave ACCUM when vs_q==1 and VGA_VSYNC_NEG==0 (vsync falling edge; vs_q is the registered VGA_VSYNC_NEG).
  - DECIDE (1 cycle): compute and register the candidate, then clear both counters.
  - COMMIT (1 cycle): update the filter and outputs.
- Candidate rules, evaluated in DECIDE:
  - red: red_cnt >= RED_THRESH and red_cnt > blue_cnt.
  - blue: blue_cnt >= BLUE_THRESH and blue_cnt > red_cnt.
  - Otherwise 00; an equal-count tie gives 00.
  - Bit 2 = (winning count >= LARGE_THRESH); bit 2 is 0 whenever the colour is 00.
- Filter (COMMIT):
  - If candidate == last_cand, agree = min(agree+1, AGREE_FRAMES). Otherwise last_cand = candidate and agree = 1.
  - If the new agree == AGREE_FRAMES, RESULT <= candidate and RESULT_VALID <= 1.
- A vsync falling edge seen while in DECIDE or COMMIT is ignored. Pixels are not counted outside ACCUM.

## Timing
- Reset values:
  - Outputs: PIXEL_OUT=0, RESULT=000, RESULT_VALID=0, FRAME_DONE=0.
  - Internal: state=ACCUM, counters=0, last_cand=000, agree=0, vs_q=1, x_d=y_d=0.
- Pixel path latency: 1 CLK from PIXEL_IN to PIXEL_OUT, which is 2 CLK from the coordinates.
- Decision latency:
  - Edge E samples the vsync falling edge; state is DECIDE after E.
  - State is COMMIT after E+1.
  - RESULT, RESULT_VALID and FRAME_DONE=1 all appear after E+2. FRAME_DONE drops after E+3.
- RESULT holds between commits and changes only on a COMMIT edge.
- RESET mid-frame or mid-DECIDE: everything returns to reset values immediately. The first commit then needs AGREE_FRAMES full frames.
- The first frame after reset may be partial. It is still classified from whatever was counted.

## Test plan
- Reset, then 3 frames of all-0xE0 window pixels (25344 red per frame), AGREE_FRAMES=2:
  - Frame 1: FRAME_DONE pulses, RESULT stays 000, RESULT_VALID stays 0.
  - Frame 2: RESULT=101 and RESULT_VALID=1 appear 3 edges after the vsync fall.
- Frame with 2500 blue pixels (0x03) and the rest black:
  - After AGREE_FRAMES frames, RESULT=010 (2500 < LARGE_THRESH).
  - PIXEL_OUT equals 8'h03 one CLK after each blue PIXEL_IN.
- Frame with red_cnt=blue_cnt=3000 -> candidate 000. Alternating red/blue frames with AGREE_FRAMES=2 -> RESULT never changes from its previous value.
- Saturation: COUNT_W=8 with an all-red frame -> red_cnt stops at 255 with no wrap; with RED_THRESH=200, the candidate is red.
- Out-of-window red pixels at x=176..639 and y=144..479 -> counts stay 0 and RESULT stays 000.
- Assert RESET during DECIDE -> all outputs are 0 on the same cycle. The next vsync fall produces FRAME_DONE with RESULT_VALID still 0.
